// File: rtl/mmaps_pkg.sv
// Shared types and defaults for the trigger-window readout path.
package mmaps_pkg;

    localparam int unsigned SIZE_DEF   = 12;
    localparam int unsigned WIDTH_DEF  = 14;
    localparam int unsigned PRE_DEF    = 16;
    localparam int unsigned POST_DEF   = 48;
    localparam int unsigned RD_LAT_DEF = 2;
    localparam int unsigned FDEPTH_DEF = 4;

    // Each FIFO word carries two tag bits above the sample: {sof, last, data}.
    localparam int unsigned TAG_BITS     = 2;
    localparam int unsigned TAG_SOF_OFS  = 1;
    localparam int unsigned TAG_LAST_OFS = 0;

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HDR   = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Saturating increment for the miss counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/trigger_window_readout_if.sv
// Event-builder stream: header/sample words with sof/last framing, valid/ready handshake.
interface trigger_window_readout_if
    import mmaps_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] out_data;
    logic             out_sof;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_sof,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sof,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/trigger_window_readout_fifo.sv
// Small output skid FIFO; head word is presented directly, count exposed for credit.
module readout_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [DW-1:0]              wr_data_i,
    input  logic                       rd_en_i,
    output logic [DW-1:0]              rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr_ok_c;
    logic          rd_ok_c;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Accept writes only with space and reads only with data.
    always_comb begin
        wr_ok_c = wr_en_i && (count_q != CW'(DEPTH));
        rd_ok_c = rd_en_i && (count_q != '0);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_c) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_ok_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({wr_ok_c, rd_ok_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

endmodule

// File: rtl/trigger_window_readout.sv
// Trigger-window readout: latches the ring-buffer pointer on trigger, waits for POST
// samples, then streams a header plus PRE+POST samples out of the ring buffer.
module trigger_window_readout
    import mmaps_pkg::*;
#(
    parameter int unsigned SIZE   = SIZE_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned PRE    = PRE_DEF,
    parameter int unsigned POST   = POST_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    parameter int unsigned FDEPTH = FDEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig,
    input  logic                     smp_wr,
    input  logic [SIZE-1:0]          rb_aout,
    output logic [SIZE-1:0]          rb_ain,
    output logic                     rb_rd_en,
    input  logic [WIDTH-1:0]         rb_dout,
    trigger_window_readout_if.master out_if,
    output logic                     busy,
    output logic [CNT_W-1:0]         trig_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);
    localparam int unsigned TOTAL = PRE + POST;
    localparam int unsigned IW    = $clog2(RD_LAT + 1);
    localparam int unsigned FW    = WIDTH + TAG_BITS;
    localparam int unsigned CW    = $clog2(FDEPTH + 1);

    if (TOTAL > (2 ** SIZE) - 8) begin : g_chk_window
        $error("trigger_window_readout: PRE+POST exceeds ring-buffer capacity");
    end
    if (POST < 1) begin : g_chk_post
        $error("trigger_window_readout: POST must be at least 1");
    end
    if (RD_LAT < 2) begin : g_chk_lat
        $error("trigger_window_readout: RD_LAT must be at least 2");
    end
    if (FDEPTH < RD_LAT + 2) begin : g_chk_fdepth
        $error("trigger_window_readout: FDEPTH must be at least RD_LAT+2");
    end

    state_e           state_q,    state_d;
    logic [SIZE-1:0]  trg_ptr_q,  trg_ptr_d;
    logic [SIZE-1:0]  wait_cnt_q, wait_cnt_d;
    logic [SIZE-1:0]  iss_cnt_q,  iss_cnt_d;
    logic             busy_q,     busy_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [SIZE-1:0]  rb_ain_q;
    logic             rb_rd_en_q;
    logic [RD_LAT-1:0] vld_pipe_q;
    logic [RD_LAT-1:0] last_pipe_q;

    logic             issue_c;
    logic             issue_last_c;
    logic             hdr_push_c;
    logic             credit_ok_c;
    logic [IW-1:0]    inflight_c;
    logic [SIZE-1:0]  rd_addr_c;
    logic             xfer_c;
    logic             fifo_wr_c;
    logic [FW-1:0]    fifo_wdata_c;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_valid;
    logic [CW-1:0]    fifo_cnt;

    // Reads in flight and the credit check that keeps the FIFO from overflowing.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_c = inflight_c + IW'(vld_pipe_q[i]);
        end
        credit_ok_c = (32'(fifo_cnt) + 32'(inflight_c)) < FDEPTH;
        rd_addr_c   = trg_ptr_q - SIZE'(PRE) + iss_cnt_q;
        xfer_c      = fifo_valid && out_if.out_ready;
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        trg_ptr_d    = trg_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        iss_cnt_d    = iss_cnt_q;
        busy_d       = busy_q;
        trig_cnt_d   = trig_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        issue_c      = 1'b0;
        issue_last_c = 1'b0;
        hdr_push_c   = 1'b0;

        if (trig && (state_q != ST_IDLE)) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    trg_ptr_d  = rb_aout;
                    trig_cnt_d = trig_cnt_q + CNT_W'(1);
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (smp_wr) begin
                    if (wait_cnt_q == SIZE'(POST - 1)) begin
                        state_d = ST_HDR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + SIZE'(1);
                    end
                end
            end
            ST_HDR: begin
                if (fifo_cnt != CW'(FDEPTH)) begin
                    hdr_push_c = 1'b1;
                    iss_cnt_d  = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (credit_ok_c) begin
                    issue_c      = 1'b1;
                    issue_last_c = (iss_cnt_q == SIZE'(TOTAL - 1));
                    iss_cnt_d    = iss_cnt_q + SIZE'(1);
                    if (issue_last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer_c && out_if.out_last) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            trg_ptr_q  <= '0;
            wait_cnt_q <= '0;
            iss_cnt_q  <= '0;
            busy_q     <= 1'b0;
            trig_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trg_ptr_q  <= trg_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            busy_q     <= busy_d;
            trig_cnt_q <= trig_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Read address, delayed read enable and the read-latency valid/last pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_ain_q    <= '0;
            rb_rd_en_q  <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            if (issue_c) begin
                rb_ain_q <= rd_addr_c;
            end
            rb_rd_en_q     <= vld_pipe_q[0];
            vld_pipe_q[0]  <= issue_c;
            last_pipe_q[0] <= issue_last_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    // FIFO write source: header word in HDR, otherwise the landing ring-buffer read.
    always_comb begin
        fifo_wr_c = hdr_push_c || vld_pipe_q[RD_LAT-1];
        if (hdr_push_c) begin
            fifo_wdata_c = {1'b1, 1'b0, WIDTH'(trig_cnt_q)};
        end else begin
            fifo_wdata_c = {1'b0, last_pipe_q[RD_LAT-1], rb_dout};
        end
    end

    readout_skid_fifo #(
        .DEPTH (FDEPTH),
        .DW    (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr_c),
        .wr_data_i (fifo_wdata_c),
        .rd_en_i   (xfer_c),
        .rd_data_o (fifo_rdata),
        .valid_o   (fifo_valid),
        .count_o   (fifo_cnt)
    );

    assign out_if.out_data  = fifo_rdata[WIDTH-1:0];
    assign out_if.out_sof   = fifo_rdata[WIDTH + TAG_SOF_OFS];
    assign out_if.out_last  = fifo_rdata[WIDTH + TAG_LAST_OFS];
    assign out_if.out_valid = fifo_valid;

    assign rb_ain   = rb_ain_q;
    assign rb_rd_en = rb_rd_en_q;
    assign busy     = busy_q;
    assign trig_cnt = trig_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_trigger_window_readout.sv
// Bench for trigger_window_readout with a negedge ring-buffer model and a beat scoreboard.
module tb_trigger_window_readout;
    localparam int unsigned SIZE   = 12;
    localparam int unsigned WIDTH  = 14;
    localparam int unsigned PRE    = 16;
    localparam int unsigned POST   = 48;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned FDEPTH = 4;
    localparam int          TOTAL  = int'(PRE + POST);
    localparam int          RB_N   = 1 << SIZE;
    localparam int          BUDGET = 3000;

    typedef struct packed {
        logic             sof;
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef struct {
        int ptr;
        int rmode;
        int extra;
        int exp_trig;
        int exp_miss;
    } row_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig;
    logic             smp_wr;
    logic [SIZE-1:0]  rb_aout;
    logic [SIZE-1:0]  rb_ain;
    logic             rb_rd_en;
    logic [WIDTH-1:0] rb_dout;
    logic             busy;
    logic [15:0]      trig_cnt;
    logic [15:0]      miss_cnt;

    always #5 clk = ~clk;

    trigger_window_readout_if #(.WIDTH(WIDTH)) out_if ();

    trigger_window_readout #(
        .SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE), .POST(POST), .RD_LAT(RD_LAT), .FDEPTH(FDEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .smp_wr   (smp_wr),
        .rb_aout  (rb_aout),
        .rb_ain   (rb_ain),
        .rb_rd_en (rb_rd_en),
        .rb_dout  (rb_dout),
        .out_if   (out_if),
        .busy     (busy),
        .trig_cnt (trig_cnt),
        .miss_cnt (miss_cnt)
    );

    int total = 0;
    int bad   = 0;

    beat_t           sb_q[$];
    logic [SIZE-1:0] addr_q[$];

    logic [WIDTH-1:0] mem [RB_N];
    int               sample_n = 0;
    logic [SIZE-1:0]  addr_lat = '0;
    int               rd_en_seen = 0;
    bit               prev_stall = 1'b0;
    beat_t            prev_beat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fill the buffer as if the write ramp had run up to sample n-1.
    function automatic void preload(input int n);
        for (int a = 0; a < RB_N; a++) begin
            int d;
            d = ((n - 1 - a) % RB_N + RB_N) % RB_N;
            mem[a] = WIDTH'(n - 1 - d);
        end
    endfunction

    // Ring buffer: negedge address latch, read data one negedge later, ramp writes.
    always @(negedge clk) begin
        if (rb_rd_en) begin
            rd_en_seen++;
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL addr_extra: got %0d, required no read", addr_lat);
            end else begin
                chk("rd_addr", 64'(addr_lat), 64'(addr_q.pop_front()));
            end
            rb_dout = mem[addr_lat];
        end
        addr_lat = rb_ain;
        if (smp_wr) begin
            mem[sample_n % RB_N] = WIDTH'(sample_n);
            sample_n++;
            rb_aout = SIZE'(sample_n);
        end
    end

    // Output monitor: scoreboard pop on transfer, hold check while stalled, FIFO bound.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", 64'({out_if.out_valid, out_if.out_sof, out_if.out_last, out_if.out_data}),
                    64'({1'b1, prev_beat}));
            end
            if (out_if.out_valid && out_if.out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_extra: got %0h, required no beat", out_if.out_data);
                end else begin
                    chk("beat", 64'({out_if.out_sof, out_if.out_last, out_if.out_data}), 64'(sb_q.pop_front()));
                    if (out_if.out_last) chk("busy_at_last", 64'(busy), 64'(1));
                end
            end
            if (out_if.out_valid && !out_if.out_ready) begin
                total++;
                if (int'(dut.fifo_cnt) > int'(FDEPTH)) begin
                    bad++;
                    $display("FAIL fifo_bound: got %0d, required <= %0d", dut.fifo_cnt, FDEPTH);
                end
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            prev_beat  = {out_if.out_sof, out_if.out_last, out_if.out_data};
        end
    end

    task automatic check_idle(input string nm);
        chk(nm, {1'b0, rb_ain, rb_rd_en, out_if.out_valid, out_if.out_sof, out_if.out_last,
                 out_if.out_data, busy, trig_cnt, miss_cnt}, 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        trig = 1'b0;
        smp_wr = 1'b0;
        out_if.out_ready = 1'b1;
        sb_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;
    endtask

    task automatic setup_ptr(input int n);
        smp_wr = 1'b0;
        sample_n = n;
        preload(n);
        rb_aout = SIZE'(n);
    endtask

    // Pulse trig and queue the expected header, samples and read addresses.
    task automatic fire_trig(input int hdr);
        int    tn;
        beat_t b;
        @(posedge clk);
        #1;
        trig = 1'b1;
        @(posedge clk);
        tn = sample_n;
        b.sof = 1'b1;
        b.last = 1'b0;
        b.data = WIDTH'(hdr);
        sb_q.push_back(b);
        for (int k = 0; k < TOTAL; k++) begin
            b.sof = 1'b0;
            b.last = (k == TOTAL - 1);
            b.data = WIDTH'(tn - int'(PRE) + k);
            sb_q.push_back(b);
            addr_q.push_back(SIZE'(tn - int'(PRE) + k));
        end
        #1;
        trig = 1'b0;
    endtask

    // Run until the window has fully drained, driving out_ready and stray triggers.
    task automatic run_window(input int rmode, input int extra);
        int cyc;
        bit t2;
        cyc = 0;
        t2 = 1'b0;
        while (cyc < BUDGET && !(sb_q.size() == 0 && addr_q.size() == 0 && !busy)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rmode == 0) out_if.out_ready = 1'b1;
            else if (cyc < 90) out_if.out_ready = (cyc % 2 == 1);
            else if (cyc < 100) out_if.out_ready = 1'b0;
            else out_if.out_ready = 1'b1;
            trig = 1'b0;
            if (extra != 0) begin
                if (cyc == 10) begin
                    trig = 1'b1;
                end else if (!t2 && rb_rd_en) begin
                    trig = 1'b1;
                    t2 = 1'b1;
                end
            end
        end
        trig = 1'b0;
        out_if.out_ready = 1'b1;
        chk("window_done", 64'(cyc < BUDGET), 64'(1));
    endtask

    initial begin
        row_t rows[5];
        int   rd0;
        int   cyc;

        rows[0] = '{ptr: 100,  rmode: 0, extra: 0, exp_trig: 1, exp_miss: 0};
        rows[1] = '{ptr: 4101, rmode: 0, extra: 0, exp_trig: 1, exp_miss: 0};
        rows[2] = '{ptr: 300,  rmode: 1, extra: 0, exp_trig: 1, exp_miss: 0};
        rows[3] = '{ptr: 2000, rmode: 0, extra: 1, exp_trig: 1, exp_miss: 2};
        rows[4] = '{ptr: 4106, rmode: 1, extra: 1, exp_trig: 1, exp_miss: 2};

        rst = 1'b1;
        trig = 1'b0;
        smp_wr = 1'b0;
        rb_aout = '0;
        rb_dout = '0;
        out_if.out_ready = 1'b1;
        preload(0);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            setup_ptr(rows[r].ptr);
            fire_trig(1);
            smp_wr = 1'b1;
            chk("busy_after_trig", 64'(busy), 64'(1));
            run_window(rows[r].rmode, rows[r].extra);
            chk("trig_cnt", 64'(trig_cnt), 64'(rows[r].exp_trig));
            chk("miss_cnt", 64'(miss_cnt), 64'(rows[r].exp_miss));
            chk("busy_end", 64'(busy), 64'(0));
        end

        // smp_wr held low after trigger: no reads until samples resume.
        do_reset();
        setup_ptr(900);
        fire_trig(1);
        rd0 = rd_en_seen;
        repeat (30) @(posedge clk);
        #1;
        chk("hold_no_reads", 64'(rd_en_seen - rd0), 64'(0));
        chk("hold_busy", 64'(busy), 64'(1));
        chk("hold_no_out", 64'(out_if.out_valid), 64'(0));
        smp_wr = 1'b1;
        run_window(0, 0);
        chk("hold_trig_cnt", 64'(trig_cnt), 64'(1));

        // Reset in the middle of READ, then a clean window afterwards.
        do_reset();
        setup_ptr(1500);
        fire_trig(1);
        smp_wr = 1'b1;
        cyc = 0;
        while (cyc < 200 && !rb_rd_en) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_read", 64'(rb_rd_en), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("rst_mid_read");
        sb_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        setup_ptr(2500);
        fire_trig(1);
        smp_wr = 1'b1;
        run_window(0, 0);
        chk("post_rst_trig_cnt", 64'(trig_cnt), 64'(1));
        chk("post_rst_miss_cnt", 64'(miss_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
